decode_imm_ctrl: RTL and testbench

// Decode-stage controller between fetch and execute. Classifies each

---
 rtl/decode_imm_ctrl_if.sv | 27 ++
 rtl/decode_imm_ctrl.sv | 121 ++++++++++++
 tb/tb_decode_imm_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_imm_ctrl_if.sv
// Handshake bundle between fetch, the decode controller and execute.
// The decode stage takes the slave view; the environment driving it takes the master view.
interface decode_imm_ctrl_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic [2:0]      out_imm_type;
  logic [31:0]     out_immediate;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_imm_type, out_immediate, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_imm_type, out_immediate, out_illegal
  );
endinterface

// File: rtl/decode_imm_ctrl.sv
// Decode-stage controller: classifies the opcode into an immType, extends the immediate
// and registers the result into the ID/EX slot, with an optional skid entry behind it.
module decode_imm_ctrl #(
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  decode_imm_ctrl_if.slave bus
);

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_NONE = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  logic            slot_valid;
  logic            skid_valid;
  logic            skid_next;
  logic            in_ready_q;
  logic [31:0]     skid_inst;
  logic [PC_W-1:0] skid_pc;

  logic            accept;
  logic            drain;
  logic            slot_open;
  logic            load_slot;
  logic [31:0]     src_inst;
  logic [PC_W-1:0] src_pc;
  logic [2:0]      dec_type;
  logic            dec_illegal;
  logic [31:0]     dec_imm;

  // The skid variant advertises a registered ready; the bypass variant looks through to execute.
  assign bus.in_ready  = SKID_EN ? in_ready_q : (in_ready_q & (bus.out_ready | !slot_valid));
  assign bus.out_valid = slot_valid;

  assign accept    = bus.in_valid & bus.in_ready;
  assign drain     = slot_valid & bus.out_ready;
  assign slot_open = !slot_valid | drain;
  assign load_slot = slot_open & (skid_valid | accept);
  assign skid_next = SKID_EN && !slot_open && (skid_valid || accept);

  // The older skid entry always refills the slot ahead of whatever fetch is presenting.
  assign src_inst = skid_valid ? skid_inst : bus.in_inst;
  assign src_pc   = skid_valid ? skid_pc   : bus.in_pc;

  always_comb begin
    dec_type    = IMM_NONE;
    dec_illegal = 1'b0;
    case (src_inst[6:0])
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: dec_type = IMM_I;
      7'b0100011:             dec_type = IMM_S;
      7'b1100011:             dec_type = IMM_B;
      7'b0110111, 7'b0010111: dec_type = IMM_U;
      7'b1101111:             dec_type = IMM_J;
      7'b0110011:             dec_type = IMM_NONE;
      default:                dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec_imm = '0;
    case (dec_type)
      IMM_I:   dec_imm = {{20{src_inst[31]}}, src_inst[31:20]};
      IMM_S:   dec_imm = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
      IMM_B:   dec_imm = {{19{src_inst[31]}}, src_inst[31], src_inst[7],
                          src_inst[30:25], src_inst[11:8], 1'b0};
      IMM_U:   dec_imm = {src_inst[31:12], 12'b0};
      IMM_J:   dec_imm = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12],
                          src_inst[20], src_inst[30:21], 1'b0};
      default: dec_imm = '0;
    endcase
  end

  // Flush wins over every handshake; the slot payload is left as-is and qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
      skid_inst  <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (slot_open) begin
        slot_valid <= skid_valid | accept;
      end
      skid_valid <= skid_next;
      in_ready_q <= SKID_EN ? !skid_next : 1'b1;
      if (!slot_open && accept) begin
        skid_inst <= bus.in_inst;
        skid_pc   <= bus.in_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_inst      <= '0;
      bus.out_pc        <= '0;
      bus.out_imm_type  <= '0;
      bus.out_immediate <= '0;
      bus.out_illegal   <= 1'b0;
    end else if (!flush && load_slot) begin
      bus.out_inst      <= src_inst;
      bus.out_pc        <= src_pc;
      bus.out_imm_type  <= dec_type;
      bus.out_immediate <= dec_imm;
      bus.out_illegal   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Self-checking bench for decode_imm_ctrl: table of hand-decoded instructions fed through
// a scoreboard, plus stall, flush and mid-operation reset sequences.
module tb_decode_imm_ctrl;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic        illegal;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t drv_exp;
  logic stall_prev = 1'b0;

  decode_imm_ctrl_if #(.PC_W(32)) bus ();

  decode_imm_ctrl #(.PC_W(32), .SKID_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: pop on handoff, push on accept; flush and reset kill everything in flight.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && bus.out_valid) begin
        checkOutput("hold_inst", 64'(bus.out_inst), 64'(dut.bus.out_inst));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 64'd1, 64'(sb.size()));
        end else begin
          vec_t e;
          e = sb.pop_front();
          checkOutput("sb_inst",     64'(bus.out_inst),      64'(e.inst));
          checkOutput("sb_pc",       64'(bus.out_pc),        64'(e.pc));
          checkOutput("sb_imm_type", 64'(bus.out_imm_type),  64'(e.imm_type));
          checkOutput("sb_imm",      64'(bus.out_immediate), 64'(e.imm));
          checkOutput("sb_illegal",  64'(bus.out_illegal),   64'(e.illegal));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(drv_exp);
      stall_prev <= bus.out_valid && !bus.out_ready;
    end
  end

  // Holds one instruction on the input until it is accepted, bounded by a cycle budget.
  task automatic applyStimulus(input vec_t v);
    logic done;
    done          = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = v.inst;
    bus.in_pc     = v.pc;
    drv_exp       = v;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"},  64'(bus.in_ready),      64'd0);
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid),     64'd0);
    checkOutput({tag, "_inst"},      64'(bus.out_inst),      64'd0);
    checkOutput({tag, "_pc"},        64'(bus.out_pc),        64'd0);
    checkOutput({tag, "_imm_type"},  64'(bus.out_imm_type),  64'd0);
    checkOutput({tag, "_imm"},       64'(bus.out_immediate), 64'd0);
    checkOutput({tag, "_illegal"},   64'(bus.out_illegal),   64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc0;
    vecs.push_back('{32'hFFF00093, 32'h0000_0100, 3'b000, 32'hFFFF_FFFF, 1'b0}); // addi -1
    vecs.push_back('{32'h00112423, 32'h0000_0104, 3'b010, 32'h0000_0008, 1'b0}); // sw 8
    vecs.push_back('{32'h123450B7, 32'h0000_0108, 3'b100, 32'h1234_5000, 1'b0}); // lui
    vecs.push_back('{32'h0000007F, 32'h0000_010C, 3'b001, 32'h0000_0000, 1'b1}); // illegal 0x7F
    vecs.push_back('{32'h00412083, 32'h0000_0110, 3'b000, 32'h0000_0004, 1'b0}); // lw 4
    vecs.push_back('{32'hFFC080E7, 32'h0000_0114, 3'b000, 32'hFFFF_FFFC, 1'b0}); // jalr -4
    vecs.push_back('{32'h30002373, 32'h0000_0118, 3'b000, 32'h0000_0300, 1'b0}); // csrrs
    vecs.push_back('{32'hFE000EE3, 32'h0000_011C, 3'b011, 32'hFFFF_FFFC, 1'b0}); // beq -4
    vecs.push_back('{32'h00001097, 32'h0000_0120, 3'b100, 32'h0000_1000, 1'b0}); // auipc
    vecs.push_back('{32'h008000EF, 32'h0000_0124, 3'b101, 32'h0000_0008, 1'b0}); // jal 8
    vecs.push_back('{32'hFFDFF0EF, 32'h0000_0128, 3'b101, 32'hFFFF_FFFC, 1'b0}); // jal -4
    vecs.push_back('{32'h002081B3, 32'h0000_012C, 3'b001, 32'h0000_0000, 1'b0}); // add
    vecs.push_back('{32'h0000000B, 32'h0000_0130, 3'b001, 32'h0000_0000, 1'b1}); // custom-0
    vecs.push_back('{32'hFE112C23, 32'h0000_0134, 3'b010, 32'hFFFF_FFF8, 1'b0}); // sw -8
    vecs.push_back('{32'h7FF00013, 32'h0000_0138, 3'b000, 32'h0000_07FF, 1'b0}); // addi 2047

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    drv_exp       = vecs[0];

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release_in_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] single ADDI, latency 1");
    bus.out_ready = 1'b1;
    applyStimulus(vecs[0]);
    checkOutput("addi_out_valid", 64'(bus.out_valid),     64'd1);
    checkOutput("addi_imm_type",  64'(bus.out_imm_type),  64'd0);
    checkOutput("addi_imm",       64'(bus.out_immediate), 64'hFFFF_FFFF);
    checkOutput("addi_illegal",   64'(bus.out_illegal),   64'd0);
    waitDrain("addi_drain");

    $display("[TB] decode table back-to-back");
    cyc0 = cyc;
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    checkOutput("throughput_cycles", 64'(cyc - cyc0), 64'(vecs.size()));
    waitDrain("table_drain");

    $display("[TB] stall with skid fill");
    bus.out_ready = 1'b0;
    applyStimulus(vecs[4]);
    applyStimulus(vecs[5]);
    checkOutput("stall_in_ready_low", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_inst  = vecs[6].inst;
    bus.in_pc    = vecs[6].pc;
    drv_exp      = vecs[6];
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stall_in_ready_held", 64'(bus.in_ready), 64'd0);
    checkOutput("stall_slot_first",    64'(bus.out_inst), 64'(vecs[4].inst));
    bus.out_ready = 1'b1;
    applyStimulus(vecs[6]);
    waitDrain("stall_drain");

    $display("[TB] flush with slot and skid full");
    bus.out_ready = 1'b0;
    applyStimulus(vecs[7]);
    applyStimulus(vecs[8]);
    bus.in_valid = 1'b1;
    bus.in_inst  = vecs[9].inst;
    bus.in_pc    = vecs[9].pc;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush_in_ready",  64'(bus.in_ready),  64'd1);

    bus.in_valid = 1'b1;
    bus.in_inst  = vecs[10].inst;
    bus.in_pc    = vecs[10].pc;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_discard_input", 64'(bus.out_valid), 64'd0);

    applyStimulus(vecs[11]);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_with_ready", 64'(bus.out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush_nothing_emerges", 64'(bus.out_valid), 64'd0);
    checkOutput("flush_sb_empty",        64'(sb.size()),     64'd0);

    $display("[TB] reset mid-stall");
    bus.out_ready = 1'b0;
    applyStimulus(vecs[12]);
    applyStimulus(vecs[13]);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_release_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    applyStimulus(vecs[14]);
    checkOutput("midreset_first_inst", 64'(bus.out_inst), 64'(vecs[14].inst));
    waitDrain("midreset_drain");

    checkOutput("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
